// File: rtl/dmem_arbiter.sv
// Two-port round-robin sequencer for the shared 8-bit data-memory port.
// Optional feature macro DMEM_ARB_LOCK_EN adds lock0 for atomic port-0 read-modify-write.
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter logic [7:0]  CMD_RD  = 8'h01,
    parameter logic [7:0]  CMD_WR  = 8'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic       lock0,
`endif
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic [7:0] cmd_memory,
    output logic [7:0] addr_memory,
    output logic [7:0] mem_wdata,
    output logic       mem_oe,
    input  logic [7:0] mem_rdata,
    output logic       busy
);

    if (MEM_LAT == 0 || MEM_LAT > 7) begin : g_bad_mem_lat
        $error("dmem_arbiter: MEM_LAT must be in 1..7");
    end

    localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StAck} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_we;
    logic       r_port;
    logic       r_last_grant;
    logic [2:0] r_lat_cnt;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       w_grant;
    logic       w_grant_port;
    logic       w_upd_last;
    logic       w_locked;

`ifdef DMEM_ARB_LOCK_EN
    logic r_lock;

    // Lock is armed by a port-0 ack with lock0 high and consumed by the next IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if (r_state == StAck) begin
            r_lock <= lock0 & ~r_port;
        end else if (r_state == StIdle) begin
            r_lock <= 1'b0;
        end
    end

    assign w_locked = r_lock & lock0 & req0;
`else
    assign w_locked = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_grant_port = 1'b0;
        w_upd_last   = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_locked) begin
                    w_grant = 1'b1;
                end else if (req0 && req1) begin
                    w_grant      = 1'b1;
                    w_grant_port = ~r_last_grant;
                    w_upd_last   = 1'b1;
                end else if (req0 || req1) begin
                    w_grant      = 1'b1;
                    w_grant_port = req1;
                    w_upd_last   = 1'b1;
                end
                if (w_grant) begin
                    w_state_nxt = StAccess;
                end
            end
            StAccess: begin
                if (r_lat_cnt == 3'd0) begin
                    w_state_nxt = StAck;
                end
            end
            StAck:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_we         <= 1'b0;
            r_port       <= 1'b0;
            r_last_grant <= 1'b1;
            r_lat_cnt    <= 3'd0;
            r_addr       <= 8'h00;
            r_wdata      <= 8'h00;
            r_rdata      <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_port    <= w_grant_port;
                r_we      <= w_grant_port ? we1 : we0;
                r_addr    <= w_grant_port ? addr1 : addr0;
                r_wdata   <= w_grant_port ? wdata1 : wdata0;
                r_lat_cnt <= LAT_LOAD;
                if (w_upd_last) begin
                    r_last_grant <= w_grant_port;
                end
            end else if (r_state == StAccess && r_lat_cnt != 3'd0) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end
            if (r_state == StAccess && r_lat_cnt == 3'd0 && !r_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        cmd_memory  = 8'h00;
        addr_memory = 8'h00;
        mem_wdata   = 8'h00;
        mem_oe      = 1'b0;
        ack0        = 1'b0;
        ack1        = 1'b0;
        if (r_state == StAccess) begin
            cmd_memory  = r_we ? CMD_WR : CMD_RD;
            addr_memory = r_addr;
            if (r_we) begin
                mem_oe    = 1'b1;
                mem_wdata = r_wdata;
            end
        end
        if (r_state == StAck) begin
            ack0 = ~r_port;
            ack1 = r_port;
        end
    end

    assign rdata = r_rdata;
    assign busy  = (r_state != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-timeline reference model.
module tb_dmem_arbiter;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, mem_oe, busy;
    logic [7:0] rdata, cmd_memory, addr_memory, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
    logic       lock0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: m_k counts position within a transaction (0 idle,
    // 1..LAT command on bus, LAT+1 ack cycle).
    int         m_k;
    int         m_port;
    int         m_last;
    logic       m_we;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic       m_lock;
    int         ack_log[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0       (lock0),
`endif
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata       (rdata),
        .cmd_memory  (cmd_memory),
        .addr_memory (addr_memory),
        .mem_wdata   (mem_wdata),
        .mem_oe      (mem_oe),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic l0;
        int   p;
        bit   locked;
        l0 = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        l0 = lock0;
`endif
        if (m_k == 0) begin
            p      = -1;
            locked = m_lock && l0 && req0;
            m_lock = 1'b0;
            if (locked)              p = 0;
            else if (req0 && req1)   p = 1 - m_last;
            else if (req0)           p = 0;
            else if (req1)           p = 1;
            if (p >= 0) begin
                m_port  = p;
                m_we    = (p == 1) ? we1 : we0;
                m_addr  = (p == 1) ? addr1 : addr0;
                m_wdata = (p == 1) ? wdata1 : wdata0;
                if (!locked) m_last = p;
                m_k = 1;
            end
        end else if (m_k == LAT + 1) begin
            m_lock = (m_port == 0) && l0;
            m_k    = 0;
        end else begin
            if (m_k == LAT && !m_we) m_rdata = mem_rdata;
            m_k++;
        end
    endtask

    task automatic check_outputs();
        bit acc;
        acc = (m_k >= 1 && m_k <= LAT);
        chk("cmd_memory", cmd_memory, acc ? (m_we ? 8'h02 : 8'h01) : 8'h00);
        chk("mem_oe", 8'(mem_oe), 8'(acc && m_we));
        if (acc) chk("addr_memory", addr_memory, m_addr);
        if (acc && m_we) chk("mem_wdata", mem_wdata, m_wdata);
        chk("ack0", 8'(ack0), 8'(m_k == LAT + 1 && m_port == 0));
        chk("ack1", 8'(ack1), 8'(m_k == LAT + 1 && m_port == 1));
        chk("ack_overlap", 8'(ack0 & ack1), 8'h00);
        chk("busy", 8'(busy), 8'(m_k != 0));
        chk("rdata", rdata, m_rdata);
        if (ack0) ack_log.push_back(0);
        if (ack1) ack_log.push_back(1);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lock0 = 1'b0;
`endif
        m_k     = 0;
        m_last  = 1;
        m_rdata = 8'h00;
        m_lock  = 1'b0;
        #1;
        chk("rst_cmd", cmd_memory, 8'h00);
        chk("rst_oe", 8'(mem_oe), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_acks", 8'({ack1, ack0}), 8'h00);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic next_req(input int p, input logic cur);
        if (m_k != 0 && m_port == p) begin
            if (m_k == LAT + 1) return 1'($urandom_range(0, 1));
            return ($urandom_range(0, 3) != 0);
        end
        if (cur) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    initial begin
        rst_n     = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        we0       = 1'b0;
        we1       = 1'b0;
        addr0     = 8'h00;
        addr1     = 8'h00;
        wdata0    = 8'h00;
        wdata1    = 8'h00;
        mem_rdata = 8'h00;
        m_port    = 0;
        m_we      = 1'b0;
        m_addr    = 8'h00;
        m_wdata   = 8'h00;
`ifdef DMEM_ARB_LOCK_EN
        lock0     = 1'b0;
`endif
        #2;
        apply_reset();

        // Single read on port 0; address change after grant must be ignored.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C; mem_rdata = 8'hA5;
        cycle();
        chk("rd_cmd", cmd_memory, 8'h01);
        chk("rd_addr", addr_memory, 8'h3C);
        addr0 = 8'hFF;
        repeat (LAT) cycle();
        chk("rd_ack0", 8'(ack0), 8'h01);
        chk("rd_rdata", rdata, 8'hA5);
        req0 = 1'b0;
        cycle();
        chk("rd_ack0_done", 8'(ack0), 8'h00);

        // Single write on port 1; data change after grant must be ignored.
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'h7E;
        cycle();
        chk("wr_cmd", cmd_memory, 8'h02);
        chk("wr_oe", 8'(mem_oe), 8'h01);
        chk("wr_data", mem_wdata, 8'h7E);
        wdata1 = 8'h00;
        repeat (LAT - 1) cycle();
        chk("wr_data_held", mem_wdata, 8'h7E);
        cycle();
        chk("wr_ack1", 8'(ack1), 8'h01);
        chk("wr_oe_ack", 8'(mem_oe), 8'h00);
        req1 = 1'b0;
        cycle();

        // Both ports requesting continuously: strict alternation from port 0.
        apply_reset();
        ack_log.delete();
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b1;
        repeat (4 * (LAT + 2)) cycle();
        chk("rr_count", 8'(ack_log.size()), 8'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_log.size()) chk("rr_order", 8'(ack_log[i]), 8'(i % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (LAT + 2) cycle();

        // req0 dropped right after grant still completes; port 1 goes next.
        apply_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h44;
        cycle();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h55;
        repeat (LAT) cycle();
        chk("drop_ack0", 8'(ack0), 8'h01);
        cycle();
        chk("drop_idle", 8'(busy), 8'h00);
        cycle();
        chk("drop_next_addr", addr_memory, 8'h55);
        repeat (LAT) cycle();
        chk("drop_ack1", 8'(ack1), 8'h01);
        req1 = 1'b0;
        cycle();

        // Reset in the middle of a write transaction.
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h77; wdata1 = 8'h5A;
        cycle();
        chk("mid_oe_before", 8'(mem_oe), 8'h01);
        #2;
        apply_reset();
        repeat (LAT + 2) cycle();

`ifdef DMEM_ARB_LOCK_EN
        // Locked read-then-write on port 0 runs back-to-back ahead of port 1.
        apply_reset();
        ack_log.delete();
        lock0 = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h99;
        for (int i = 0; i < 10 && ack_log.size() < 1; i++) cycle();
        we0 = 1'b1; wdata0 = 8'hC3;
        for (int i = 0; i < 10 && ack_log.size() < 2; i++) cycle();
        lock0 = 1'b0; req0 = 1'b0;
        for (int i = 0; i < 10 && ack_log.size() < 3; i++) cycle();
        chk("lock_count", 8'(ack_log.size()), 8'd3);
        if (ack_log.size() >= 3) begin
            chk("lock_first", 8'(ack_log[0]), 8'd0);
            chk("lock_second", 8'(ack_log[1]), 8'd0);
            chk("lock_third", 8'(ack_log[2]), 8'd1);
        end
        req1 = 1'b0;
        cycle();
`endif

        // Random traffic against the model.
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            req0      = next_req(0, req0);
            req1      = next_req(1, req1);
            we0       = 1'($urandom_range(0, 1));
            we1       = 1'($urandom_range(0, 1));
            addr0     = 8'($urandom);
            addr1     = 8'($urandom);
            wdata0    = 8'($urandom);
            wdata1    = 8'($urandom);
            mem_rdata = 8'($urandom);
`ifdef DMEM_ARB_LOCK_EN
            lock0     = ($urandom_range(0, 3) == 0);
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
